// File: rtl/param_fifo.sv
// ----------------------------------------------------------------------------
// param_fifo: single-clock synchronous FIFO with configurable width and depth.
// The depth does not need to be a power of two. Status flags are decoded
// combinationally from the occupancy count. The write-ack and overflow/underflow
// pulses are registered. The read port is either registered (FWFT=0) or
// first-word-fall-through (FWFT=1).
// ----------------------------------------------------------------------------
module param_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    parameter int FWFT         = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LEVEL);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LEVEL);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // The pointers wrap explicitly at the last slot, so a non-power-of-two
    // depth never leaves unused addresses in the ring.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Status flags are decoded directly from the occupancy count.
    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign almostfull  = (count >= AFULL_CNT) && !full;
    assign almostempty = (count <= AEMPTY_CNT) && !empty;

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same cycle. A read of an empty FIFO is never accepted.
    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;

    // Storage array: written on accepted writes only.
    // NOTE: the memory has no reset on purpose. Stale entries are unreachable
    // once the pointers and count are cleared, and leaving out the reset keeps
    // the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: all state uses non-blocking assignments, so every register
    // samples pre-edge values. When the FIFO is full and a read and a write
    // are accepted together, wr_ptr equals rd_ptr. The read then still sees
    // the oldest word while the write replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_accept) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One-cycle handshake pulses that report last cycle's outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue shown combinationally. Output is zero while empty,
            // so reset and empty reads both leave data_out at 0.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_registered
            // Registered read port: data_out is loaded on an accepted read and
            // holds its value otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out <= '0;
                end else if (rd_accept) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning width of data_in and data_out.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning number of entries (any value >= 2; power of two not required).
REQ-003 The block SHALL have parameter AFULL_LEVEL, default FIFO_DEPTH-1, meaning count at or above which almostfull asserts (1..FIFO_DEPTH-1).
REQ-004 The block SHALL have parameter AEMPTY_LEVEL, default 1, meaning count at or below which almostempty asserts, with count != 0 (1..FIFO_DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 0, meaning 0 = registered-read mode and 1 = first-word-fall-through mode.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have the remaining ports as listed:
  - wr_en  input  1  write request
  - rd_en  input  1  read request
  - data_in  input  DATA_WIDTH  write data
  - data_out  output  DATA_WIDTH  read data
  - full, empty, almostfull, almostempty  output  1 each  combinational status from count
  - wr_ack  output  1  registered, previous-cycle write accepted
  - overflow  output  1  registered, previous-cycle write rejected
  - underflow  output  1  registered, previous-cycle read rejected
  - count  output  $clog2(FIFO_DEPTH+1)  occupancy

Function
REQ-009 full SHALL equal (count == FIFO_DEPTH); empty SHALL equal (count == 0).
REQ-010 almostfull SHALL equal (count >= AFULL_LEVEL) && !full; almostempty SHALL equal (count <= AEMPTY_LEVEL) && !empty.
REQ-011 A write SHALL be accepted when wr_en && (!full || rd_en); on acceptance data_in is stored at wr_ptr, wr_ptr advances, and wr_ack = 1 in the next cycle.
REQ-012 A write with wr_en && full && !rd_en SHALL be rejected: memory, wr_ptr and count unchanged, overflow = 1 in the next cycle, wr_ack = 0.
REQ-013 A read SHALL be accepted when rd_en && !empty; rd_ptr advances by one.
REQ-014 A read with rd_en && empty SHALL be rejected: rd_ptr and data_out unchanged, underflow = 1 in the next cycle; a simultaneous write is still accepted.
REQ-015 wr_ack, overflow and underflow SHALL each be single-cycle pulses, 0 in any cycle following no such event.
REQ-016 count SHALL be +1 on write-only accept, -1 on read-only accept, and unchanged on both-accept or neither.
REQ-017 wr_ptr and rd_ptr SHALL range 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0.
REQ-018 FWFT=0: on an accepted read, data_out SHALL register mem[rd_ptr] (1-cycle latency); data_out holds otherwise.
REQ-019 FWFT=1: data_out SHALL continuously present mem[rd_ptr] (0-cycle latency, valid while !empty); an accepted read pops the head.
REQ-020 On simultaneous accepted read and write with full=1, the read SHALL return the oldest entry and the write SHALL occupy the freed slot.

Reset
REQ-021 rst_n = 0 SHALL immediately, independent of clk, clear wr_ptr, rd_ptr, count, wr_ack, overflow, underflow and data_out to 0, giving empty=1, full=0, almostempty=0, almostfull=0.
REQ-022 Memory contents SHALL NOT be required to reset.
REQ-023 Reset asserted mid-operation SHALL discard all stored entries; the first write after deassertion SHALL land at address 0.

Verification (DATA_WIDTH=16, FIFO_DEPTH=8, defaults otherwise)
REQ-024 Write 8 words 0x0001..0x0008 -> wr_ack each next cycle, count 1..8, almostfull at count 7, full at 8.
REQ-025 A 9th write with rd_en=0 -> overflow=1 next cycle, wr_ack=0, count stays 8; then 8 reads -> data_out 0x0001..0x0008 in order, empty=1.
REQ-026 Read when empty -> underflow=1 next cycle, data_out unchanged, count 0.
REQ-027 Full FIFO with wr_en=rd_en=1, data_in=0xBEEF -> data_out=0x0001, count stays 8, wr_ack=1, overflow=0; 0xBEEF is read back last.
REQ-028 Write 12 and read 12 interleaved (pointer wrap) -> data in order; drop rst_n mid-stream -> count=0 and empty=1 immediately, without waiting for a clk edge.
REQ-029 FWFT=1, write 0x00AA into empty FIFO -> data_out=0x00AA once empty=0, before any rd_en.
